// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit multiplexed seven-segment display driver.
// Holds the blank and off patterns, the digit count, and the active-low hex glyph table.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [7:0]  AN_OFF     = 8'hFF;

  // Active-low cathode patterns {g,f,e,d,c,b,a}, indexed by nibble value 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-nibble to seven-segment decoder that produces an active-low output.
// Ports:
//   nibble : 4-bit input, the hex value to show.
//   seg_c  : 7-bit output {g,f,e,d,c,b,a}, active low, combinational.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Drives an 8-digit multiplexed common-anode display from a 32-bit word, one hex nibble per digit.
// Each digit gets its own time slot. The word is latched once per frame so that no digit shows a torn value.
// Every slot opens with GHOST_CYC dark cycles to suppress ghosting between digits.
// Optional macro LEADING_ZERO_BLANK_EN: when it is defined, leading zero digits 7..1 are dark.
// Ports:
//   clk       : input, system clock.
//   reset     : input, synchronous active-low reset.
//   disp_data : input, 32-bit word. Nibble k appears on digit k, and digit 0 is the rightmost.
//   blank     : input. When it is 1, all anodes are off. Scanning continues.
//   an        : output, 8-bit anode enables, active low, one-hot-low when a digit is lit.
//   seg       : output, 7-bit cathodes {g,f,e,d,c,b,a}, active low.
//   dp        : output, decimal point, active low, always off.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned GHOST_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] disp_data,
  input  logic        blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      shd;

  logic       tick_c;
  logic       ghost_c;
  logic       lead_dark_c;
  logic       lit_c;
  logic [3:0] nibble_c;
  logic [6:0] glyph_c;

  assign tick_c   = (cnt == CNT_W'(CLK_DIV - 1));
  assign nibble_c = shd[{idx, 2'b00} +: 4];

  // The anti-ghosting window at the start of each slot. A zero width disables it entirely.
  generate
    if (GHOST_CYC == 0) begin : g_no_ghost
      assign ghost_c = 1'b0;
    end else begin : g_ghost
      assign ghost_c = (32'(cnt) < GHOST_CYC);
    end
  endgenerate

  // A digit above 0 is dark when its nibble and every higher nibble are zero.
`ifdef LEADING_ZERO_BLANK_EN
  assign lead_dark_c = (idx != IDX_W'(0)) && ((shd >> {idx, 2'b00}) == 32'd0);
`else
  assign lead_dark_c = 1'b0;
`endif

  assign lit_c = !blank && !ghost_c && !lead_dark_c;

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble_c),
    .seg_c  (glyph_c)
  );

  // Slot counter, digit index, and per-frame shadow latch. The outputs are registered from the current state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
      shd <= '0;
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      if (tick_c) begin
        cnt <= '0;
        idx <= idx + IDX_W'(1);
        if (idx == IDX_W'(NUM_DIGITS - 1)) begin
          shd <= disp_data;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      an  <= lit_c ? ~(8'b1 << idx) : AN_OFF;
      seg <= lit_c ? glyph_c : SEG_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned GHOST_CYC = 1;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] disp_data;
  logic        blank;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  exp_t q[$];
  exp_t ex;
  int   checks = 0;
  int   errors = 0;
  int   n  = 0;
  int   st = 0;

  int          m_cnt = 0;
  int          m_idx = 0;
  logic [31:0] m_shd = '0;

  seg7_scan_driver #(
    .CLK_DIV   (CLK_DIV),
    .GHOST_CYC (GHOST_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .disp_data (disp_data),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: ref_seg = 7'h40; 4'h1: ref_seg = 7'h79; 4'h2: ref_seg = 7'h24; 4'h3: ref_seg = 7'h30;
      4'h4: ref_seg = 7'h19; 4'h5: ref_seg = 7'h12; 4'h6: ref_seg = 7'h02; 4'h7: ref_seg = 7'h78;
      4'h8: ref_seg = 7'h00; 4'h9: ref_seg = 7'h10; 4'hA: ref_seg = 7'h08; 4'hB: ref_seg = 7'h03;
      4'hC: ref_seg = 7'h46; 4'hD: ref_seg = 7'h21; 4'hE: ref_seg = 7'h06; default: ref_seg = 7'h0E;
    endcase
  endfunction

  // The reference model samples the inputs as they will be seen at the next edge and queues the registered result.
  task automatic model_step();
    exp_t e;
    logic lit;
    logic [31:0] hi;
    if (!reset) begin
      m_cnt = 0; m_idx = 0; m_shd = '0;
      e.an = 8'hFF; e.seg = 7'h7F;
    end else begin
      hi  = m_shd >> (4 * m_idx);
      lit = !blank && (m_cnt >= int'(GHOST_CYC));
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx != 0 && hi == 32'd0) lit = 1'b0;
`endif
      e.an  = lit ? ~(8'b1 << m_idx) : 8'hFF;
      e.seg = lit ? ref_seg(hi[3:0]) : 7'h7F;
      if (m_cnt == int'(CLK_DIV) - 1) begin
        m_cnt = 0;
        if (m_idx == 7) m_shd = disp_data;
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    q.push_back(e);
  endtask

  // Advances one clock and pops the expectation for the output produced at that edge.
  task automatic cycle();
    model_step();
    @(negedge clk);
    ex = q.pop_front();
    st = n;
    n  = n + 1;
  endtask

  task automatic test_reset();
    reset = 1'b0; blank = 1'b0; disp_data = 32'h12345678;
    repeat (3) begin
      cycle();
      checks++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold an=%h seg=%h dp=%b expected an=ff seg=7f dp=1", an, seg, dp);
      end
    end
    reset = 1'b1;
    disp_data = 32'h89ABCDEF;
    n = 0;
  endtask

  task automatic test_first_frame();
    repeat (32) begin
      cycle();
      checks++;
      if (an !== ex.an || seg !== ex.seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL first_frame st=%0d an=%h seg=%h dp=%b expected an=%h seg=%h", st, an, seg, dp, ex.an, ex.seg);
      end
      if (an !== 8'hFF) begin
        checks++;
        if (seg !== 7'h40) begin
          errors++;
          $display("FAIL first_frame_zero st=%0d seg=%h expected 40", st, seg);
        end
      end
    end
  endtask

  task automatic test_scan();
    logic [6:0] tbl [8];
    logic [7:0] want_an;
    logic [6:0] want_seg;
    int d;
    tbl = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    repeat (32) begin
      cycle();
      d = (st / 4) % 8;
      want_an  = (st % 4 == 0) ? 8'hFF : ~(8'b1 << d);
      want_seg = (st % 4 == 0) ? 7'h7F : tbl[d];
      checks++;
      if (an !== want_an || seg !== want_seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL scan st=%0d an=%h seg=%h dp=%b expected an=%h seg=%h", st, an, seg, dp, want_an, want_seg);
      end
      checks++;
      if (an !== ex.an || seg !== ex.seg) begin
        errors++;
        $display("FAIL scan_model st=%0d an=%h seg=%h expected an=%h seg=%h", st, an, seg, ex.an, ex.seg);
      end
      if (st == 45) disp_data = 32'h00000000;
    end
  endtask

  task automatic test_no_tear();
    repeat (32) begin
      cycle();
      checks++;
      if (an !== ex.an || seg !== ex.seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL no_tear st=%0d an=%h seg=%h dp=%b expected an=%h seg=%h", st, an, seg, dp, ex.an, ex.seg);
      end
      if (an !== 8'hFF) begin
        checks++;
        if (seg !== 7'h40) begin
          errors++;
          $display("FAIL no_tear_zero st=%0d seg=%h expected 40", st, seg);
        end
      end
    end
  endtask

  task automatic test_blank();
    logic was_blank;
    logic [7:0] want_an;
    repeat (32) begin
      blank = (n >= 106 && n < 116);
      was_blank = blank;
      cycle();
      checks++;
      if (an !== ex.an || seg !== ex.seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL blank_model st=%0d an=%h seg=%h dp=%b expected an=%h seg=%h", st, an, seg, dp, ex.an, ex.seg);
      end
      if (was_blank) begin
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F) begin
          errors++;
          $display("FAIL blank_dark st=%0d an=%h seg=%h expected an=ff seg=7f", st, an, seg);
        end
      end else if (ex.an != 8'hFF) begin
        want_an = ~(8'b1 << ((st / 4) % 8));
        checks++;
        if (an !== want_an) begin
          errors++;
          $display("FAIL blank_resume st=%0d an=%h expected %h", st, an, want_an);
        end
      end
    end
    blank = 1'b0;
  endtask

  task automatic test_collision();
    while (n % 32 != 31) begin
      cycle();
      checks++;
      if (an !== ex.an || seg !== ex.seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL pre_collision st=%0d an=%h seg=%h expected an=%h seg=%h", st, an, seg, ex.an, ex.seg);
      end
    end
    reset = 1'b0;
    disp_data = 32'hDEADBEEF;
    cycle();
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL collision_reset an=%h seg=%h dp=%b expected an=ff seg=7f dp=1", an, seg, dp);
    end
    reset = 1'b1;
    disp_data = 32'h000000A5;
    n = 0;
    cycle();
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F) begin
      errors++;
      $display("FAIL collision_ghost an=%h seg=%h expected an=ff seg=7f", an, seg);
    end
    cycle();
    checks++;
    if (an !== 8'hFE || seg !== 7'h40) begin
      errors++;
      $display("FAIL collision_no_latch an=%h seg=%h expected an=fe seg=40", an, seg);
    end
  endtask

  task automatic test_frame_a5();
    logic [7:0] want_an;
    logic [6:0] want_seg;
    int d;
    repeat (30) begin
      cycle();
      checks++;
      if (an !== ex.an || seg !== ex.seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL zero_frame st=%0d an=%h seg=%h expected an=%h seg=%h", st, an, seg, ex.an, ex.seg);
      end
    end
    repeat (32) begin
      cycle();
      d = (st / 4) % 8;
      if (st % 4 == 0) begin
        want_an = 8'hFF; want_seg = 7'h7F;
      end else if (d == 0) begin
        want_an = 8'hFE; want_seg = 7'h12;
      end else if (d == 1) begin
        want_an = 8'hFD; want_seg = 7'h08;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        want_an = 8'hFF; want_seg = 7'h7F;
`else
        want_an = ~(8'b1 << d); want_seg = 7'h40;
`endif
      end
      checks++;
      if (an !== want_an || seg !== want_seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL frame_a5 st=%0d an=%h seg=%h dp=%b expected an=%h seg=%h", st, an, seg, dp, want_an, want_seg);
      end
      checks++;
      if (an !== ex.an || seg !== ex.seg) begin
        errors++;
        $display("FAIL frame_a5_model st=%0d an=%h seg=%h expected an=%h seg=%h", st, an, seg, ex.an, ex.seg);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    blank = 1'b0;
    disp_data = '0;
    test_reset();
    test_first_frame();
    test_scan();
    test_no_tear();
    test_blank();
    test_collision();
    test_frame_a5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumer end of the debug display-select path: takes the 32-bit display word chosen by the selector and drives an 8-digit multiplexed, common-anode seven-segment display as 8 hex nibbles.
- Time-multiplexes one digit per slot, latches the word once per frame so a digit never shows a torn value, and inserts a short anti-ghosting blank between slots.

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot (≥ 2 * GHOST_CYC; default ≈1 kHz slot at 100 MHz).
- GHOST_CYC, 16, cycles at the start of each slot with all anodes off (0 disables).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- disp_data  in  32  word to display; nibble k shown on digit k (digit 0 = rightmost).
- blank  in  1  1 = all anodes off; scanning continues.
- an  out  8  anode enables, active low, one-hot-low when lit.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low; always 1 (off).

Behaviour:
- Reset (reset==0 at posedge): slot counter cnt=0, digit index idx=0, shadow word shd=0, an=8'hFF, seg=7'h7F, dp=1.
- cnt counts 0..CLK_DIV-1 and wraps to 0. A tick is cnt==CLK_DIV-1.
- On tick, idx increments mod 8 (7 wraps to 0).
- Frame latch: on a tick with idx==7, shd <= disp_data. This is the only load point. The first frame after reset shows 00000000.
- Outputs are registered with 1-cycle latency: values at cycle t+1 derive from cnt/idx/shd/blank at cycle t.
  - an = 8'hFF if blank==1 or cnt < GHOST_CYC.
  - Otherwise an = ~(8'b1 << idx).
  - seg = hex_to_seg7(shd[4*idx+3 : 4*idx]) whenever the digit is lit, else 7'h7F.
- Encoding, active low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- blank does not stop cnt/idx/frame latching. Deasserting blank resumes mid-slot with no restart.
- Changes on disp_data mid-frame are ignored until the next frame latch.
- Reset mid-slot: takes effect on the next edge and overrides everything, including a coincident tick/latch.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: after the per-digit blanking rules above, a digit k (k≥1) whose nibble and all higher nibbles of shd are zero has an forced high (dark) for its slot. Digit 0 always lights, so shd=0 shows a single "0".
- Undefined: all 8 digits always light (subject to blank/GHOST_CYC).

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'h7F, AN_OFF = 8'hFF, NUM_DIGITS = 8.
  - The 16-entry hex segment constant table.
- Sub-module hex_to_seg7: purely combinational, 4-bit nibble in, 7-bit active-low segment out, table from seg7_pkg. The top holds the counters, shadow register and output registers.

Test Plan:
- Reset: hold reset=0 for 3 cycles with disp_data=32'h12345678 → an=FF, seg=7F, dp=1 throughout. After release (CLK_DIV=4, GHOST_CYC=1), the first frame shows all digits seg=40.
- Frame latch/scan (CLK_DIV=4, GHOST_CYC=1): drive 32'h89ABCDEF from reset → second frame shows:
  - an=FE with seg=0E for 3 of 4 cycles (1 ghost cycle an=FF), then
  - an=FD with seg=06, …, an=7F with seg=00.
- No tearing: change disp_data to 32'h00000000 mid-frame 2 → frame 2 completes with 89ABCDEF values; frame 3 shows all 40.
- blank: assert blank for 10 cycles mid-frame → an=FF for those cycles (+1 latency). idx keeps advancing, so after release the lit digit matches the cycle count.
- Wrap/reset collision: reset=0 on the exact cycle of an idx==7 tick → shd stays 0, idx=0, cnt=0, outputs AN_OFF/SEG_BLANK next cycle.
- LEADING_ZERO_BLANK_EN defined, shd=32'h000000A5 → only digits 0 (seg=12) and 1 (seg=08) light; shd=0 → only digit 0 lights with seg=40.
